// File: rtl/hmmm_mem_arbiter.sv
// rtl/hmmm_mem_arbiter.sv - CPU/debug SRAM arbiter with strobe sequencer
// Outputs are registered from next-state decode so strobes never glitch.
module hmmm_mem_arbiter #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATA_WIDTH    = 16,
  parameter int WAIT_CYCLES   = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_adr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ack,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_adr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  input  logic                  dbg_halt,
  output logic                  cpu_stall,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [ADDR_WIDTH-1:0] sram_adr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  output logic                  sram_drive,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [3:0] streak;
  logic       cmd_we, cmd_dbg;
  logic       grant_cpu, grant_dbg;
  logic       we_nxt, dbg_nxt;
  logic       ce_n_nxt, oe_n_nxt, we_n_nxt, drive_nxt;
  logic       cpu_ack_nxt, dbg_ack_nxt;
  logic       last_access;

  assign last_access = (state == S_ACCESS) && (wait_cnt == 4'd1);
  assign cpu_stall   = cpu_req & ~cpu_ack;

  // Debug forward progress: once the CPU has won BURST_MAX times in a row
  // over a waiting debug request, debug takes the next slot.
  always_comb begin
    grant_cpu = 1'b0;
    grant_dbg = 1'b0;
    if (state == S_IDLE) begin
      if (dbg_halt)
        grant_dbg = dbg_req;
      else if (cpu_req && dbg_req && (streak == BURST_MAX))
        grant_dbg = 1'b1;
      else if (cpu_req)
        grant_cpu = 1'b1;
      else if (dbg_req)
        grant_dbg = 1'b1;
    end
  end

  always_comb begin
    state_nxt   = state;
    we_nxt      = cmd_we;
    dbg_nxt     = cmd_dbg;
    ce_n_nxt    = 1'b1;
    oe_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    drive_nxt   = 1'b0;
    cpu_ack_nxt = 1'b0;
    dbg_ack_nxt = 1'b0;
    if (grant_dbg) begin
      we_nxt  = dbg_we;
      dbg_nxt = 1'b1;
    end else if (grant_cpu) begin
      we_nxt  = cpu_we;
      dbg_nxt = 1'b0;
    end
    case (state)
      S_IDLE:    if (grant_cpu || grant_dbg) state_nxt = S_SETUP;
      S_SETUP:   state_nxt = S_ACCESS;
      S_ACCESS:  if (wait_cnt == 4'd1) state_nxt = cmd_we ? S_RECOVER : S_DONE;
      S_RECOVER: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
    case (state_nxt)
      S_SETUP: begin
        ce_n_nxt  = 1'b0;
        drive_nxt = we_nxt;
      end
      S_ACCESS: begin
        ce_n_nxt  = 1'b0;
        oe_n_nxt  = we_nxt;
        we_n_nxt  = ~we_nxt;
        drive_nxt = we_nxt;
      end
      S_RECOVER: begin
        ce_n_nxt  = 1'b0;
        drive_nxt = 1'b1;
      end
      S_DONE: begin
        cpu_ack_nxt = ~dbg_nxt;
        dbg_ack_nxt = dbg_nxt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      streak     <= '0;
      cmd_we     <= 1'b0;
      cmd_dbg    <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_drive <= 1'b0;
      sram_adr   <= '0;
      sram_wdata <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cmd_we     <= we_nxt;
      cmd_dbg    <= dbg_nxt;
      sram_ce_n  <= ce_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_drive <= drive_nxt;
      cpu_ack    <= cpu_ack_nxt;
      dbg_ack    <= dbg_ack_nxt;
      if (grant_dbg) begin
        sram_adr   <= dbg_adr;
        sram_wdata <= dbg_wdata;
        streak     <= '0;
      end else if (grant_cpu) begin
        sram_adr   <= cpu_adr;
        sram_wdata <= cpu_wdata;
        if (!dbg_req)
          streak <= '0;
        else if (streak < BURST_MAX)
          streak <= streak + 4'd1;
      end
      if (state == S_SETUP)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_ACCESS)
        wait_cnt <= wait_cnt - 4'd1;
      if (last_access && !cmd_we) begin
        if (cmd_dbg)
          dbg_rdata <= sram_rdata;
        else
          cpu_rdata <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hmmm_mem_arbiter.sv
// tb/tb_hmmm_mem_arbiter.sv - directed vector bench for hmmm_mem_arbiter
// Instance 0 runs WAIT_CYCLES=1, instance 1 runs WAIT_CYCLES=3; each has its own SRAM model.
module tb_hmmm_mem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        cpu_req[2], cpu_we[2], cpu_ack[2], cpu_stall[2];
  logic [7:0]  cpu_adr[2];
  logic [15:0] cpu_wdata[2], cpu_rdata[2];
  logic        dbg_req[2], dbg_we[2], dbg_ack[2], dbg_halt[2];
  logic [7:0]  dbg_adr[2];
  logic [15:0] dbg_wdata[2], dbg_rdata[2];
  logic        ce_n[2], oe_n[2], we_n[2], drive[2];
  logic [7:0]  s_adr[2];
  logic [15:0] s_wdata[2], s_rdata[2];
  logic [15:0] mem[2][256];
  logic        prev_we_n[2];

  int n_vec;
  int n_err;
  int n_overlap;

  hmmm_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(1), .MAX_CPU_BURST(4)) u_a (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_adr(cpu_adr[0]), .cpu_wdata(cpu_wdata[0]),
    .cpu_rdata(cpu_rdata[0]), .cpu_ack(cpu_ack[0]),
    .dbg_req(dbg_req[0]), .dbg_we(dbg_we[0]), .dbg_adr(dbg_adr[0]), .dbg_wdata(dbg_wdata[0]),
    .dbg_rdata(dbg_rdata[0]), .dbg_ack(dbg_ack[0]),
    .dbg_halt(dbg_halt[0]), .cpu_stall(cpu_stall[0]),
    .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram_adr(s_adr[0]), .sram_wdata(s_wdata[0]), .sram_drive(drive[0]), .sram_rdata(s_rdata[0])
  );

  hmmm_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_CYCLES(3), .MAX_CPU_BURST(4)) u_b (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_adr(cpu_adr[1]), .cpu_wdata(cpu_wdata[1]),
    .cpu_rdata(cpu_rdata[1]), .cpu_ack(cpu_ack[1]),
    .dbg_req(dbg_req[1]), .dbg_we(dbg_we[1]), .dbg_adr(dbg_adr[1]), .dbg_wdata(dbg_wdata[1]),
    .dbg_rdata(dbg_rdata[1]), .dbg_ack(dbg_ack[1]),
    .dbg_halt(dbg_halt[1]), .cpu_stall(cpu_stall[1]),
    .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram_adr(s_adr[1]), .sram_wdata(s_wdata[1]), .sram_drive(drive[1]), .sram_rdata(s_rdata[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 2; g++) begin : g_ram
    assign s_rdata[g] = mem[g][s_adr[g]];
  end

  // Write commits on the cycle we_n has returned high with ce_n and data still asserted.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ce_n[i] && we_n[i] && drive[i] && !prev_we_n[i])
        mem[i][s_adr[i]] = s_wdata[i];
      if (!oe_n[i] && !we_n[i])
        n_overlap = n_overlap + 1;
      prev_we_n[i] = we_n[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic txn(input int i, input bit dbg, input bit we, input logic [7:0] adr,
                     input logic [15:0] wd, output int lat, output logic [15:0] rd,
                     output int oe_lo, output int we_lo, output int drv_hi,
                     output int my_acks, output int other_acks);
    lat = 0; rd = '0; oe_lo = 0; we_lo = 0; drv_hi = 0; my_acks = 0; other_acks = 0;
    if (dbg) begin
      dbg_req[i] = 1'b1; dbg_we[i] = we; dbg_adr[i] = adr; dbg_wdata[i] = wd;
    end else begin
      cpu_req[i] = 1'b1; cpu_we[i] = we; cpu_adr[i] = adr; cpu_wdata[i] = wd;
    end
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!oe_n[i]) oe_lo++;
      if (!we_n[i]) we_lo++;
      if (drive[i]) drv_hi++;
      if (dbg ? cpu_ack[i] : dbg_ack[i]) other_acks++;
      if (dbg ? dbg_ack[i] : cpu_ack[i]) begin
        my_acks++;
        if (lat == 0) begin
          lat = c;
          rd = dbg ? dbg_rdata[i] : cpu_rdata[i];
          cpu_req[i] = 1'b0;
          dbg_req[i] = 1'b0;
        end
      end
      if (lat != 0 && c >= lat + 4) break;
    end
    cpu_req[i] = 1'b0;
    dbg_req[i] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          dbg;
    bit          we;
    logic [7:0]  adr;
    logic [15:0] wd;
    logic [15:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat, oe_lo, we_lo, drv_hi, my_acks, other_acks, n, acks;
    logic [15:0] rd;
    int order[6];
    int at[6];
    int exp_order[6];
    int stall_err, cpu_during, dbg_cnt, nxt;

    vecs[0] = '{0, 0, 8'h10, 16'h0000, 16'h002D, 3};
    vecs[1] = '{0, 1, 8'h40, 16'h1111, 16'h002D, 4};
    vecs[2] = '{1, 0, 8'h20, 16'h0000, 16'h1234, 3};
    vecs[3] = '{0, 0, 8'h40, 16'h0000, 16'h1111, 3};
    vecs[4] = '{1, 1, 8'h00, 16'hBEEF, 16'h1234, 4};
    vecs[5] = '{1, 0, 8'h00, 16'h0000, 16'hBEEF, 3};
    vecs[6] = '{0, 1, 8'hFF, 16'h5A5A, 16'h1111, 4};
    vecs[7] = '{0, 0, 8'hFF, 16'h0000, 16'h5A5A, 3};
    exp_order = '{0, 0, 0, 0, 1, 0};

    n_vec = 0; n_err = 0; n_overlap = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_adr[i] = '0; cpu_wdata[i] = '0;
      dbg_req[i] = 0; dbg_we[i] = 0; dbg_adr[i] = '0; dbg_wdata[i] = '0;
      dbg_halt[i] = 0; prev_we_n[i] = 1'b1;
      for (int a = 0; a < 256; a++) mem[i][a] = '0;
    end
    mem[0][8'h10] = 16'h002D;
    mem[0][8'h20] = 16'h1234;

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d ce_n", i), 32'(ce_n[i]), 1);
      chk($sformatf("rst%0d oe_n", i), 32'(oe_n[i]), 1);
      chk($sformatf("rst%0d we_n", i), 32'(we_n[i]), 1);
      chk($sformatf("rst%0d drive", i), 32'(drive[i]), 0);
      chk($sformatf("rst%0d adr", i), 32'(s_adr[i]), 0);
      chk($sformatf("rst%0d wdata", i), 32'(s_wdata[i]), 0);
      chk($sformatf("rst%0d cpu_rdata", i), 32'(cpu_rdata[i]), 0);
      chk($sformatf("rst%0d dbg_rdata", i), 32'(dbg_rdata[i]), 0);
      chk($sformatf("rst%0d cpu_ack", i), 32'(cpu_ack[i]), 0);
      chk($sformatf("rst%0d dbg_ack", i), 32'(dbg_ack[i]), 0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 8; k++) begin
      txn(0, vecs[k].dbg, vecs[k].we, vecs[k].adr, vecs[k].wd, lat, rd, oe_lo, we_lo, drv_hi, my_acks, other_acks);
      chk($sformatf("v%0d latency", k), 32'(lat), 32'(vecs[k].exp_lat));
      chk($sformatf("v%0d rdata", k), 32'(rd), 32'(vecs[k].exp_rd));
      chk($sformatf("v%0d oe_low", k), 32'(oe_lo), vecs[k].we ? 0 : 1);
      chk($sformatf("v%0d we_low", k), 32'(we_lo), vecs[k].we ? 1 : 0);
      chk($sformatf("v%0d drive_high", k), 32'(drv_hi), vecs[k].we ? 3 : 0);
      chk($sformatf("v%0d ack_count", k), 32'(my_acks), 1);
      chk($sformatf("v%0d other_ack", k), 32'(other_acks), 0);
      if (vecs[k].we)
        chk($sformatf("v%0d mem", k), 32'(mem[0][vecs[k].adr]), 32'(vecs[k].wd));
    end

    txn(1, 1, 1, 8'hFF, 16'hA5A5, lat, rd, oe_lo, we_lo, drv_hi, my_acks, other_acks);
    chk("w3 write latency", 32'(lat), 6);
    chk("w3 we_low", 32'(we_lo), 3);
    chk("w3 drive_high", 32'(drv_hi), 5);
    chk("w3 oe_low", 32'(oe_lo), 0);
    chk("w3 cpu_ack", 32'(other_acks), 0);
    chk("w3 mem", 32'(mem[1][8'hFF]), 32'h0000A5A5);
    txn(1, 1, 0, 8'hFF, 16'h0000, lat, rd, oe_lo, we_lo, drv_hi, my_acks, other_acks);
    chk("w3 read latency", 32'(lat), 5);
    chk("w3 read rdata", 32'(rd), 32'h0000A5A5);
    chk("w3 read oe_low", 32'(oe_lo), 3);

    // Fairness: both ports streaming reads
    cpu_we[0] = 0; cpu_adr[0] = 8'h10; dbg_we[0] = 0; dbg_adr[0] = 8'h20;
    cpu_req[0] = 1; dbg_req[0] = 1;
    n = 0; stall_err = 0;
    for (int k = 0; k < 6; k++) begin order[k] = 9; at[k] = 0; end
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (cpu_stall[0] !== (cpu_req[0] & ~cpu_ack[0])) stall_err++;
      if (cpu_ack[0] || dbg_ack[0]) begin
        order[n] = cpu_ack[0] ? 0 : 1;
        at[n] = c;
        n++;
      end
      if (n == 6) begin
        cpu_req[0] = 0; dbg_req[0] = 0;
        break;
      end
    end
    cpu_req[0] = 0; dbg_req[0] = 0;
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++)
      chk($sformatf("fair grant%0d owner", k), 32'(order[k]), 32'(exp_order[k]));
    for (int k = 1; k < 6; k++)
      chk($sformatf("fair spacing%0d", k), 32'(at[k] - at[k-1]), 4);
    chk("fair cpu_stall", 32'(stall_err), 0);

    // Loader mode
    dbg_halt[0] = 1; cpu_req[0] = 1; dbg_req[0] = 1;
    cpu_during = 0; dbg_cnt = 0; nxt = 9;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (dbg_halt[0]) begin
        if (cpu_ack[0]) cpu_during++;
        if (dbg_ack[0]) begin
          dbg_cnt++;
          if (dbg_cnt == 3) dbg_halt[0] = 0;
        end
      end else if (cpu_ack[0] || dbg_ack[0]) begin
        nxt = cpu_ack[0] ? 0 : 1;
        cpu_req[0] = 0; dbg_req[0] = 0;
        break;
      end
    end
    cpu_req[0] = 0; dbg_req[0] = 0; dbg_halt[0] = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("halt cpu_ack", 32'(cpu_during), 0);
    chk("halt dbg grants", 32'(dbg_cnt), 3);
    chk("halt release owner", 32'(nxt), 0);

    // Request withdrawal in SETUP
    cpu_we[0] = 0; cpu_adr[0] = 8'h20; cpu_req[0] = 1;
    @(posedge clk);
    #1;
    cpu_req[0] = 0;
    acks = 0; oe_lo = 0; rd = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (!oe_n[0]) oe_lo++;
      if (cpu_ack[0]) begin acks++; rd = cpu_rdata[0]; end
    end
    @(posedge clk);
    #1;
    chk("withdraw ack_count", 32'(acks), 1);
    chk("withdraw oe_low", 32'(oe_lo), 1);
    chk("withdraw rdata", 32'(rd), 32'h00001234);

    // Reset during the second ACCESS cycle of a WAIT_CYCLES=3 write
    cpu_we[1] = 1; cpu_adr[1] = 8'h33; cpu_wdata[1] = 16'h7777; cpu_req[1] = 1;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre-reset we_n", 32'(we_n[1]), 0);
    reset_n = 1'b0;
    #1;
    chk("abort ce_n", 32'(ce_n[1]), 1);
    chk("abort we_n", 32'(we_n[1]), 1);
    chk("abort oe_n", 32'(oe_n[1]), 1);
    chk("abort drive", 32'(drive[1]), 0);
    cpu_req[1] = 0;
    acks = 0;
    @(negedge clk);
    if (cpu_ack[1]) acks++;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (cpu_ack[1] || dbg_ack[1]) acks++;
    end
    @(posedge clk);
    #1;
    chk("abort ack_count", 32'(acks), 0);
    chk("abort mem", 32'(mem[1][8'h33]), 0);

    txn(0, 0, 0, 8'h10, 16'h0000, lat, rd, oe_lo, we_lo, drv_hi, my_acks, other_acks);
    chk("post-reset latency", 32'(lat), 3);
    chk("post-reset rdata", 32'(rd), 32'h0000002D);
    chk("post-reset oe_low", 32'(oe_lo), 1);
    chk("post-reset dbg_ack", 32'(other_acks), 0);
    txn(1, 0, 0, 8'h33, 16'h0000, lat, rd, oe_lo, we_lo, drv_hi, my_acks, other_acks);
    chk("post-reset w3 latency", 32'(lat), 5);
    chk("post-reset w3 rdata", 32'(rd), 0);

    chk("oe_we overlap", 32'(n_overlap), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hmmm_mem_arbiter.md
# hmmm_mem_arbiter

Single-port SRAM arbiter and access sequencer shared by the HMMM core and a debug/loader port. It sits between both requesters and the board SRAM (active-low ce/oe/we, 8-bit address, 16-bit data). It serialises requests and generates the SRAM strobe sequence with a programmable access width. It also guarantees the debug port forward progress while the core streams fetches.

## Interface
- `ADDR_WIDTH`, default 8: SRAM address width.
- `DATA_WIDTH`, default 16: SRAM data width.
- `WAIT_CYCLES`, default 1, legal range 1–15: number of cycles the strobe (oe_n or we_n) is held low.
- `MAX_CPU_BURST`, default 4, legal range 1–15: maximum number of consecutive CPU grants while a debug request is pending.

Ports:
- `clk`  in  1  single system clock, rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  CPU request, held until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_adr`  in  ADDR_WIDTH  CPU address.
- `cpu_wdata`  in  DATA_WIDTH  CPU write data.
- `cpu_rdata`  out  DATA_WIDTH  CPU read data, valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `dbg_req`, `dbg_we`, `dbg_adr`, `dbg_wdata`, `dbg_rdata`, `dbg_ack`: same definitions as the CPU port.
- `dbg_halt`  in  1  while 1, the CPU is never granted (loader mode).
- `cpu_stall`  out  1  = `cpu_req` & ~`cpu_ack`.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  SRAM strobes, active low.
- `sram_adr`  out  ADDR_WIDTH  registered SRAM address.
- `sram_wdata`  out  DATA_WIDTH  registered write data.
- `sram_drive`  out  1  tristate enable for `sram_wdata` onto the shared bus.
- `sram_rdata`  in  DATA_WIDTH  SRAM bus read value.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RECOVER, DONE. Every output is registered except `cpu_stall`.
- **Arbitration** happens in IDLE only. The winner's command (we, adr, wdata) is latched on the grant edge; later changes on the requester inputs are ignored until its ack.
  - If `dbg_halt`=1: debug wins whenever `dbg_req`=1.
  - Else if both requesters are pending and the streak counter equals MAX_CPU_BURST: debug wins.
  - Else if `cpu_req`=1: CPU wins.
  - Else if `dbg_req`=1: debug wins.
  - Else stay in IDLE.
- **Streak counter** (4 bits):
  - Increments on a CPU grant while `dbg_req`=1.
  - Clears on a CPU grant while `dbg_req`=0.
  - Clears on any debug grant.
  - Saturates at MAX_CPU_BURST.
- **State actions:**
  - IDLE → SETUP on grant. All strobes are high and `sram_drive`=0.
  - SETUP (1 cycle): `sram_ce_n`=0 and `sram_adr` is valid. For a write, `sram_drive`=1 and `sram_we_n`=1. Next state is ACCESS. The wait counter loads WAIT_CYCLES.
  - ACCESS (WAIT_CYCLES cycles):
    - Read: `sram_oe_n`=0. `sram_rdata` is sampled into the winner's rdata register on the last ACCESS cycle's closing edge. Next state is DONE.
    - Write: `sram_we_n`=0 and `sram_drive`=1. Next state is RECOVER.
  - RECOVER (writes only, 1 cycle): `sram_we_n`=1, `sram_ce_n`=0, `sram_drive`=1, giving data hold after the we_n rising edge. Next state is DONE.
  - DONE (1 cycle): strobes are high and `sram_drive`=0. The winner's ack is 1. Next state is always IDLE.
- `sram_oe_n` and `sram_we_n` are never low in the same cycle.
- `sram_drive`=1 only in SETUP, ACCESS or RECOVER of a write.
- The rdata registers hold their last value until the next read completes for that port. Writes do not change rdata.
- **Request withdrawal:** a requester that drops req after its grant still completes. The ack still pulses and the SRAM access is performed.
- **Repeat requests:** req still high in the cycle after ack is a new request. It is arbitrated in the following IDLE.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - state = IDLE, streak = 0;
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1, `sram_drive` = 0;
  - `sram_adr` = 0, `sram_wdata` = 0;
  - `cpu_rdata`, `dbg_rdata` = 0; `cpu_ack`, `dbg_ack` = 0.
- Reset asserted mid-access forces all strobes high and `sram_drive`=0 immediately, with no ack. The aborted transaction is lost.
- Latency is measured from the edge that samples req=1 in IDLE to the first cycle with ack=1:
  - read: WAIT_CYCLES+2;
  - write: WAIT_CYCLES+3.
- Minimum request-to-request spacing on one port equals the latency plus 1 cycle (the IDLE arbitration cycle).
- With WAIT_CYCLES=1, a back-to-back CPU read stream yields one ack every 4 cycles.

## Test plan
- **Single CPU read:** reset, then `cpu_req`=1, `cpu_we`=0, `cpu_adr`=0x10, with the SRAM model holding 0x002D at that address. Required: `sram_oe_n` is low for exactly 1 cycle, `cpu_ack` pulses 3 cycles after the grant edge, `cpu_rdata`=0x002D, and `dbg_ack` stays 0.
- **Debug write with WAIT_CYCLES=3:** `dbg_we`=1, `dbg_adr`=0xFF, `dbg_wdata`=0xA5A5. Required:
  - `sram_we_n` low for 3 cycles;
  - `sram_drive` high for 5 cycles (SETUP+3+RECOVER);
  - `dbg_ack` 6 cycles after the grant;
  - memory[0xFF]=0xA5A5.
- **Fairness with MAX_CPU_BURST=4:** `cpu_req` and `dbg_req` are both held high continuously. Required grant order: CPU, CPU, CPU, CPU, DBG, CPU… Also required: `cpu_stall`=1 whenever `cpu_ack`=0.
- **Loader mode:** `dbg_halt`=1 with both requesters high. Required: only debug grants occur, and `cpu_ack` stays 0. After `dbg_halt` drops, the next IDLE grants the CPU.
- **Reset mid-write:** assert `reset_n`=0 in the second ACCESS cycle. Required: strobes go high and `sram_drive` goes 0 in the same cycle, no ack is issued, and the next request after reset behaves like the single-read case.
- **Request withdrawal:** `cpu_req` drops in SETUP. Required: the access completes and `cpu_ack` still pulses once, with no second access.
